// File: rtl/dyn_adder_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : dyn_adder_n_if
//  Purpose  : Operand/result handshake bundle for dyn_adder_n.
//             master = operand producer / result consumer
//             slave  = the adder itself
//  Signals  : in_valid/in_ready, a, b, cin      operand transfer
//             out_valid/out_ready, sum, cout    result transfer
//             latency                           wait count of current/last op
//             op_count                          saturating consumed-result count
//  Revision : 1.0  initial release
// ============================================================================
interface dyn_adder_n_if #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int CNT_W          = 16
);
  localparam int c_LAT_W = $clog2(WIDTH / BITS_PER_CYCLE + 2);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [c_LAT_W-1:0] latency;
  logic [CNT_W-1:0]   op_count;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, latency, op_count
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, latency, op_count
  );
endinterface
`default_nettype wire

// File: rtl/dyn_adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : dyn_adder_n
//  Purpose  : Adder whose result latency depends on the operands. The wait
//             count W = 1 + floor(L / BITS_PER_CYCLE), where L is the longest
//             run of carry-propagate bits (a ^ b), emulates a carry chain that
//             resolves BITS_PER_CYCLE bits per clock.
//  Ports    : adder_clk  sole clock (rising edge)
//             reset      asynchronous, active-high
//             bus        dyn_adder_n_if.slave (operands in, result out)
//  Revision : 1.0  initial release
// ============================================================================
module dyn_adder_n #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int CNT_W          = 16
) (
  input  wire logic      adder_clk,
  input  wire logic      reset,
  dyn_adder_n_if.slave   bus
);

  localparam int c_LAT_W = $clog2(WIDTH / BITS_PER_CYCLE + 2);
  localparam int c_L_W   = $clog2(WIDTH + 1);
  localparam logic [c_L_W-1:0] c_BPC     = c_L_W'(BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [c_LAT_W-1:0] r_latency;
  logic [CNT_W-1:0]   r_op_count;
  logic [c_LAT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;

  logic [WIDTH-1:0]   w_p;
  logic [c_L_W-1:0]   w_run;
  logic [c_L_W-1:0]   w_max;
  logic [c_L_W-1:0]   w_quot;
  logic [c_LAT_W-1:0] w_wait;
  logic [WIDTH:0]     w_sum_full;

  // Propagate mask of the operands presented for capture.
  assign w_p = bus.a ^ bus.b;

  // Longest run of consecutive propagate bits: a running length that resets
  // on every 0, with the maximum tracked across the word.
  always_comb begin
    w_run = '0;
    w_max = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_p[i]) begin
        w_run = w_run + 1'b1;
      end else begin
        w_run = '0;
      end
      if (w_run > w_max) begin
        w_max = w_run;
      end
    end
  end

  // The quotient never exceeds WIDTH/BITS_PER_CYCLE, so W always fits c_LAT_W.
  assign w_quot = w_max / c_BPC;
  assign w_wait = c_LAT_W'(w_quot) + c_LAT_W'(1);

  // Result is formed from the captured operands only, so later changes on the
  // bus cannot disturb an in-flight operation.
  assign w_sum_full = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};

  always_ff @(posedge adder_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_latency   <= '0;
      r_op_count  <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_cin      <= bus.cin;
            r_cnt      <= w_wait;
            r_latency  <= w_wait;
            r_in_ready <= 1'b0;
            r_state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_cnt <= r_cnt - 1'b1;
          // Counter value 1 marks the W-th edge after capture.
          if (r_cnt == c_LAT_W'(1)) begin
            r_sum       <= w_sum_full[WIDTH-1:0];
            r_cout      <= w_sum_full[WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Returning to IDLE with in_ready low-to-high guarantees at least one
          // idle cycle before the next capture.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
            if (r_op_count != c_CNT_MAX) begin
              r_op_count <= r_op_count + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.latency   = r_latency;
  assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_dyn_adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dyn_adder_n
//  Purpose  : Self-checking bench for dyn_adder_n. Two instances: default
//             parameters (32/8/16) and a narrow one (16/3/2) for counter
//             saturation. Expected results are queued at stimulus time and
//             compared when the DUT presents out_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dyn_adder_n;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dyn_adder_n_if #(.WIDTH(32), .BITS_PER_CYCLE(8), .CNT_W(16)) bus32 ();
  dyn_adder_n_if #(.WIDTH(16), .BITS_PER_CYCLE(3), .CNT_W(2))  bus16 ();

  dyn_adder_n #(.WIDTH(32), .BITS_PER_CYCLE(8), .CNT_W(16)) u_dut32 (
    .adder_clk (clk),
    .reset     (rst),
    .bus       (bus32)
  );

  dyn_adder_n #(.WIDTH(16), .BITS_PER_CYCLE(3), .CNT_W(2)) u_dut16 (
    .adder_clk (clk),
    .reset     (rst),
    .bus       (bus16)
  );

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          lat;
  } exp_t;

  exp_t sb32[$];
  exp_t sb16[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_cnt32 = 0;
  int exp_cnt16 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int longest_run(input logic [63:0] p, input int w);
    int run  = 0;
    int best = 0;
    for (int i = 0; i < w; i++) begin
      run = p[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // One full operation on the 32-bit instance; called at a negedge while idle.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input int hold, input bit toggle);
    exp_t        e;
    logic [32:0] full;
    int          n;
    full  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.sum = {32'd0, full[31:0]};
    e.cout = full[32];
    e.lat = 1 + longest_run({32'd0, a ^ b}, 32) / 8;
    check("idle_in_ready32", bus32.in_ready, 1);
    bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.in_valid = 1'b1;
    sb32.push_back(e);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.a = ~a; bus32.b = ~b; bus32.cin = ~cin;
    check("busy_in_ready32", bus32.in_ready, 0);
    check("latency_load32", bus32.latency, e.lat);
    n = 0;
    while (!bus32.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("valid_edges32", n, e.lat);
    check("sb32_size", sb32.size(), 1);
    if (sb32.size() > 0) e = sb32.pop_front();
    check("sum32", bus32.sum, e.sum);
    check("cout32", bus32.cout, e.cout);
    check("latency32", bus32.latency, e.lat);
    for (int i = 0; i < hold; i++) begin
      if (toggle) begin
        bus32.in_valid = 1'($urandom);
        bus32.a = $urandom; bus32.b = $urandom; bus32.cin = 1'($urandom);
      end
      @(negedge clk);
      check("hold_valid32", bus32.out_valid, 1);
      check("hold_sum32", bus32.sum, e.sum);
      check("hold_cout32", bus32.cout, e.cout);
      check("hold_lat32", bus32.latency, e.lat);
      check("hold_in_ready32", bus32.in_ready, 0);
    end
    if (toggle) bus32.in_valid = 1'b1;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.out_ready = 1'b0;
    if (exp_cnt32 < 65535) exp_cnt32++;
    check("op_count32", bus32.op_count, exp_cnt32);
    check("rel_valid32", bus32.out_valid, 0);
    check("rel_in_ready32", bus32.in_ready, 1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t        e;
    logic [16:0] full;
    int          n;
    full  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum = {48'd0, full[15:0]};
    e.cout = full[16];
    e.lat = 1 + longest_run({48'd0, a ^ b}, 16) / 3;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.in_valid = 1'b1;
    sb16.push_back(e);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a = ~a; bus16.b = ~b;
    n = 0;
    while (!bus16.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("valid_edges16", n, e.lat);
    check("sb16_size", sb16.size(), 1);
    if (sb16.size() > 0) e = sb16.pop_front();
    check("sum16", bus16.sum, e.sum);
    check("cout16", bus16.cout, e.cout);
    check("latency16", bus16.latency, e.lat);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    if (exp_cnt16 < 3) exp_cnt16++;
    check("op_count16", bus16.op_count, exp_cnt16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus32.in_ready, 1);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_sum", bus32.sum, 0);
    check("rst_latency", bus32.latency, 0);
    check("rst_op_count", bus32.op_count, 0);
    check("rst_op_count16", bus16.op_count, 0);

    // First edge after reset release captures the pending request.
    rst = 1'b0;
    op32(32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0);
    op32(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);
    op32(32'h00FF_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
    op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10, 1'b1);

    // Abort a W=5 operation two edges into evaluation.
    bus32.a = 32'hFFFF_FFFF; bus32.b = '0; bus32.cin = 1'b1; bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", bus32.in_ready, 1);
    check("abort_out_valid", bus32.out_valid, 0);
    check("abort_sum", bus32.sum, 0);
    check("abort_cout", bus32.cout, 0);
    check("abort_latency", bus32.latency, 0);
    check("abort_op_count", bus32.op_count, 0);
    repeat (2) @(negedge clk);
    check("abort_hold_valid", bus32.out_valid, 0);
    rst = 1'b0;
    exp_cnt32 = 0;
    exp_cnt16 = 0;
    op32(32'd3, 32'd4, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op32($urandom, $urandom, 1'($urandom), 0, 1'b0);
    end

    // Narrow instance: longest possible run, then random traffic past saturation.
    op16(16'hFFFF, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
